// File: rtl/dcache_nway.sv
// N-way set-associative write-back/write-allocate data cache between the LSU and a line-wide bus.
// Round-robin replacement per set, preferring invalid ways; fence-style clean with optional invalidate.
module dcache_nway #(
    parameter int ADDR_W     = 32,
    parameter int WAYS       = 4,
    parameter int SETS       = 128,
    parameter int LINE_BYTES = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_valid,
    input  logic                      i_reqtyp,
    input  logic [ADDR_W-1:0]         i_addr,
    input  logic [1:0]                i_size,
    input  logic [63:0]               i_wdata,
    input  logic                      i_clean,
    input  logic                      i_inval,
    output logic                      o_ready,
    output logic [63:0]               o_rdata,
    output logic                      o_mem_valid,
    output logic                      o_mem_reqtyp,
    output logic [ADDR_W-1:0]         o_mem_addr,
    output logic [LINE_BYTES*8-1:0]   o_mem_wdata,
    output logic [1:0]                o_mem_size,
    input  logic                      i_mem_ready,
    input  logic [LINE_BYTES*8-1:0]   i_mem_rdata
);
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int LINE_W = LINE_BYTES * 8;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int CNT_W  = IDX_W + WAY_W;
    localparam int WIDE_W = LINE_W + 64;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETS * WAYS - 1);

    typedef enum logic [2:0] {IDLE, HIT, WBUS, RBUS, CLN_SCAN, CLN_WBUS} state_t;

    state_t                  state_q;
    logic [TAG_W-1:0]        tag_mem  [WAYS][SETS];
    logic [LINE_W-1:0]       data_mem [WAYS][SETS];
    logic [WAYS-1:0][SETS-1:0] valid_q, dirty_q;
    logic [WAY_W-1:0]        rr_q [SETS];
    logic [WAY_W-1:0]        vic_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [63:0]             rdata_q;
    logic                    mem_reqtyp_q;
    logic [ADDR_W-1:0]       mem_addr_q;
    logic [LINE_W-1:0]       mem_wdata_q;

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [OFF_W-1:0]  req_off;
    logic [OFF_W+2:0]  shamt;
    assign req_tag = i_addr[ADDR_W-1 -: TAG_W];
    assign req_idx = i_addr[OFF_W +: IDX_W];
    assign req_off = i_addr[OFF_W-1:0];
    assign shamt   = {req_off, 3'b000};

    logic             hit_any;
    logic [WAY_W-1:0] hit_way, vic_way;
    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        vic_way = rr_q[req_idx];
        // Descending scan so the lowest-index invalid way wins.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[w][req_idx]) vic_way = WAY_W'(w);
            if (valid_q[w][req_idx] && tag_mem[w][req_idx] == req_tag) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    logic [LINE_W-1:0] hit_line, wr_line;
    logic [WIDE_W-1:0] rd_wide, wd_wide, bm_wide;
    logic [63:0]       size_mask;
    always_comb begin
        case (i_size)
            2'b00:   size_mask = 64'h0000_0000_0000_00FF;
            2'b01:   size_mask = 64'h0000_0000_0000_FFFF;
            2'b10:   size_mask = 64'h0000_0000_FFFF_FFFF;
            default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        hit_line = data_mem[hit_way][req_idx];
        // Zero-extended shifts: bytes past the line end read as 0.
        rd_wide  = {64'b0, hit_line} >> shamt;
        wd_wide  = {{LINE_W{1'b0}}, i_wdata & size_mask} << shamt;
        bm_wide  = {{LINE_W{1'b0}}, size_mask} << shamt;
        wr_line  = (hit_line & ~bm_wide[LINE_W-1:0]) | (wd_wide[LINE_W-1:0] & bm_wide[LINE_W-1:0]);
    end

    logic [WAY_W-1:0] cln_way;
    logic [IDX_W-1:0] cln_set;
    logic             cln_dirty, cnt_last;
    assign cln_way   = cnt_q[CNT_W-1:IDX_W];
    assign cln_set   = cnt_q[IDX_W-1:0];
    assign cln_dirty = valid_q[cln_way][cln_set] & dirty_q[cln_way][cln_set];
    assign cnt_last  = (cnt_q == CNT_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            dirty_q      <= '0;
            for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
            vic_q        <= '0;
            cnt_q        <= '0;
            rdata_q      <= '0;
            mem_reqtyp_q <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (i_valid) begin
                    if (i_clean) begin
                        state_q <= CLN_SCAN;
                        rdata_q <= '0;
                    end else if (hit_any) begin
                        state_q <= HIT;
                        rdata_q <= i_reqtyp ? 64'b0 : rd_wide[63:0];
                        if (i_reqtyp) begin
                            data_mem[hit_way][req_idx] <= wr_line;
                            dirty_q[hit_way][req_idx]  <= 1'b1;
                        end
                    end else begin
                        vic_q <= vic_way;
                        if (valid_q[vic_way][req_idx] && dirty_q[vic_way][req_idx]) begin
                            state_q      <= WBUS;
                            mem_reqtyp_q <= 1'b1;
                            mem_addr_q   <= {tag_mem[vic_way][req_idx], req_idx, {OFF_W{1'b0}}};
                            mem_wdata_q  <= data_mem[vic_way][req_idx];
                        end else begin
                            state_q      <= RBUS;
                            mem_reqtyp_q <= 1'b0;
                            mem_addr_q   <= {req_tag, req_idx, {OFF_W{1'b0}}};
                        end
                    end
                end
                HIT: state_q <= IDLE;
                WBUS: if (i_mem_ready) begin
                    dirty_q[vic_q][req_idx] <= 1'b0;
                    state_q      <= RBUS;
                    mem_reqtyp_q <= 1'b0;
                    mem_addr_q   <= {req_tag, req_idx, {OFF_W{1'b0}}};
                end
                RBUS: if (i_mem_ready) begin
                    data_mem[vic_q][req_idx] <= i_mem_rdata;
                    tag_mem[vic_q][req_idx]  <= req_tag;
                    valid_q[vic_q][req_idx]  <= 1'b1;
                    dirty_q[vic_q][req_idx]  <= 1'b0;
                    if (vic_q == rr_q[req_idx])
                        rr_q[req_idx] <= (rr_q[req_idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[req_idx] + 1'b1;
                    state_q <= IDLE;
                end
                CLN_SCAN: begin
                    if (cln_dirty) begin
                        state_q      <= CLN_WBUS;
                        mem_reqtyp_q <= 1'b1;
                        mem_addr_q   <= {tag_mem[cln_way][cln_set], cln_set, {OFF_W{1'b0}}};
                        mem_wdata_q  <= data_mem[cln_way][cln_set];
                    end else begin
                        if (i_inval) valid_q[cln_way][cln_set] <= 1'b0;
                        if (cnt_last) begin
                            cnt_q   <= '0;
                            state_q <= IDLE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                CLN_WBUS: if (i_mem_ready) begin
                    dirty_q[cln_way][cln_set] <= 1'b0;
                    if (i_inval) valid_q[cln_way][cln_set] <= 1'b0;
                    if (cnt_last) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
                        state_q <= CLN_SCAN;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Clean completion is flagged in the same cycle the final entry retires.
    assign o_ready      = (state_q == HIT)
                        | (state_q == CLN_SCAN && !cln_dirty && cnt_last)
                        | (state_q == CLN_WBUS && i_mem_ready && cnt_last);
    assign o_rdata      = rdata_q;
    assign o_mem_valid  = (state_q == WBUS) | (state_q == RBUS) | (state_q == CLN_WBUS);
    assign o_mem_reqtyp = mem_reqtyp_q;
    assign o_mem_addr   = mem_addr_q;
    assign o_mem_wdata  = mem_wdata_q;
    assign o_mem_size   = 2'b11;
endmodule

// File: tb/tb_dcache_nway.sv
// Directed bench for dcache_nway (4 ways, 128 sets, 16-byte lines) with an in-task bus responder.
module tb_dcache_nway;
    localparam int BUS_LAT = 2;
    localparam int SCAN    = 128 * 4;

    logic         i_clk = 1'b0;
    logic         i_rst, i_valid, i_reqtyp, i_clean, i_inval, i_mem_ready;
    logic [31:0]  i_addr;
    logic [1:0]   i_size;
    logic [63:0]  i_wdata;
    logic [127:0] i_mem_rdata;
    logic         o_ready, o_mem_valid, o_mem_reqtyp;
    logic [63:0]  o_rdata;
    logic [31:0]  o_mem_addr;
    logic [127:0] o_mem_wdata;
    logic [1:0]   o_mem_size;

    dcache_nway #(.ADDR_W(32), .WAYS(4), .SETS(128), .LINE_BYTES(16)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_reqtyp(i_reqtyp),
        .i_addr(i_addr), .i_size(i_size), .i_wdata(i_wdata), .i_clean(i_clean),
        .i_inval(i_inval), .o_ready(o_ready), .o_rdata(o_rdata),
        .o_mem_valid(o_mem_valid), .o_mem_reqtyp(o_mem_reqtyp), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_mem_size(o_mem_size), .i_mem_ready(i_mem_ready),
        .i_mem_rdata(i_mem_rdata)
    );

    always #5 i_clk = ~i_clk;

    int n_chk = 0, n_fail = 0;
    int r_cyc, r_nwb, r_nrd;
    logic r_got;
    logic [63:0]  r_rdata;
    logic [31:0]  r_wb_addr [4];
    logic [127:0] r_wb_data;
    logic [31:0]  r_rd_addr;
    logic [63:0]  exp64;
    logic [127:0] ln;

    function automatic logic [127:0] fill_of(input logic [31:0] a);
        if (a == 32'h8000_0010) return 128'h00112233_44556677_8899AABB_CCDDEEFF;
        return {a, ~a, a ^ 32'h5A5A_5A5A, 32'h0BAD_F00D};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic access(input logic typ, input logic [31:0] a, input logic [1:0] sz,
                          input logic [63:0] wd, input logic cln, input logic inv);
        int wait_cnt;
        i_valid = 1'b1; i_reqtyp = typ; i_addr = a; i_size = sz; i_wdata = wd;
        i_clean = cln; i_inval = inv;
        r_got = 1'b0; r_cyc = 0; r_nwb = 0; r_nrd = 0; r_rdata = '0; wait_cnt = 0;
        while (!r_got && r_cyc < 2000) begin
            @(posedge i_clk); #1;
            r_cyc++;
            i_mem_ready = 1'b0;
            if (o_ready) begin
                r_got = 1'b1;
                r_rdata = o_rdata;
            end else if (o_mem_valid) begin
                wait_cnt++;
                if (wait_cnt == BUS_LAT) begin
                    wait_cnt = 0;
                    i_mem_ready = 1'b1;
                    if (o_mem_reqtyp) begin
                        if (r_nwb < 4) r_wb_addr[r_nwb] = o_mem_addr;
                        r_wb_data = o_mem_wdata;
                        r_nwb++;
                    end else begin
                        r_rd_addr = o_mem_addr;
                        i_mem_rdata = fill_of(o_mem_addr);
                        r_nrd++;
                    end
                end
            end
        end
        i_valid = 1'b0; i_clean = 1'b0; i_inval = 1'b0;
        chk("req_done", r_got, 1);
        @(posedge i_clk); #1;
    endtask

    initial begin
        i_rst = 1'b1; i_valid = 0; i_reqtyp = 0; i_addr = '0; i_size = 0; i_wdata = '0;
        i_clean = 0; i_inval = 0; i_mem_ready = 0; i_mem_rdata = '0;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_ready", o_ready, 0);
        chk("rst_mem_valid", o_mem_valid, 0);
        chk("rst_mem_reqtyp", o_mem_reqtyp, 0);
        chk("rst_rdata", o_rdata, 0);
        chk("mem_size", o_mem_size, 2'b11);
        i_rst = 1'b0;
        @(posedge i_clk); #1;

        // Cold miss
        access(0, 32'h8000_0010, 2'b11, 0, 0, 0);
        chk("cold_cyc", r_cyc, 2 + BUS_LAT);
        chk("cold_nrd", r_nrd, 1);
        chk("cold_nwb", r_nwb, 0);
        chk("cold_rd_addr", r_rd_addr, 32'h8000_0010);
        chk("cold_rdata", r_rdata, 64'h8899AABB_CCDDEEFF);

        // Write hit upper dword, read back, partial read near line end
        access(1, 32'h8000_0018, 2'b11, 64'hDEAD_BEEF_0000_0001, 0, 0);
        chk("wr_cyc", r_cyc, 1);
        chk("wr_nrd", r_nrd, 0);
        chk("wr_rdata", r_rdata, 0);
        access(0, 32'h8000_0018, 2'b11, 0, 0, 0);
        chk("rb_cyc", r_cyc, 1);
        chk("rb_rdata", r_rdata, 64'hDEAD_BEEF_0000_0001);
        access(0, 32'h8000_001E, 2'b01, 0, 0, 0);
        chk("tail_rdata", r_rdata, 64'h0000_0000_0000_DEAD);

        // Fill remaining ways of set 1
        for (int k = 1; k < 4; k++) begin
            access(0, 32'h8000_0010 + 32'(k) * 32'h800, 2'b11, 0, 0, 0);
            chk("fill_cyc", r_cyc, 2 + BUS_LAT);
            chk("fill_nwb", r_nwb, 0);
        end

        // 5th tag evicts dirty way 0
        access(0, 32'h8000_2010, 2'b11, 0, 0, 0);
        chk("ev5_cyc", r_cyc, 2 + 2 * BUS_LAT);
        chk("ev5_nwb", r_nwb, 1);
        chk("ev5_wb_addr", r_wb_addr[0], 32'h8000_0010);
        chk("ev5_wb_data", r_wb_data, 128'hDEADBEEF_00000001_8899AABB_CCDDEEFF);
        chk("ev5_rd_addr", r_rd_addr, 32'h8000_2010);
        ln = fill_of(32'h8000_2010);
        chk("ev5_rdata", r_rdata, ln[63:0]);

        // 6th tag evicts clean way 1
        access(0, 32'h8000_2810, 2'b11, 0, 0, 0);
        chk("ev6_cyc", r_cyc, 2 + BUS_LAT);
        chk("ev6_nwb", r_nwb, 0);
        for (int k = 2; k < 6; k++) begin
            access(0, 32'h8000_0010 + 32'(k) * 32'h800, 2'b11, 0, 0, 0);
            chk("resident_cyc", r_cyc, 1);
            chk("resident_nrd", r_nrd, 0);
        end

        // Dirty two lines with sub-word stores (upper wdata bits must be ignored)
        access(1, 32'h8000_2014, 2'b10, 64'hFFFF_FFFF_CAFE_F00D, 0, 0);
        access(1, 32'h8000_1813, 2'b00, 64'hFFFF_FFFF_FFFF_FFA5, 0, 0);

        access(0, 0, 2'b11, 0, 1, 0);
        chk("cln_cyc", r_cyc, SCAN + 2 * BUS_LAT);
        chk("cln_nwb", r_nwb, 2);
        chk("cln_wb0", r_wb_addr[0], 32'h8000_2010);
        chk("cln_wb1", r_wb_addr[1], 32'h8000_1810);
        chk("cln_nrd", r_nrd, 0);

        access(0, 32'h8000_2010, 2'b11, 0, 0, 0);
        chk("post_cln_cyc_a", r_cyc, 1);
        chk("post_cln_bus_a", r_nwb + r_nrd, 0);
        chk("post_cln_data_a", r_rdata, 64'hCAFE_F00D_0BAD_F00D);
        access(0, 32'h8000_2018, 2'b11, 0, 0, 0);
        chk("upper_untouched", r_rdata, {32'h8000_2010, 32'h7FFF_DFEF});
        access(0, 32'h8000_1810, 2'b11, 0, 0, 0);
        chk("post_cln_cyc_b", r_cyc, 1);
        ln = fill_of(32'h8000_1810);
        exp64 = ln[63:0];
        exp64[31:24] = 8'hA5;
        chk("post_cln_data_b", r_rdata, exp64);

        // Clean + invalidate with one dirty line
        access(1, 32'h8000_1010, 2'b11, 64'h1234_5678_9ABC_DEF0, 0, 0);
        access(0, 0, 2'b11, 0, 1, 1);
        chk("inv_cyc", r_cyc, SCAN + BUS_LAT);
        chk("inv_nwb", r_nwb, 1);
        chk("inv_wb_addr", r_wb_addr[0], 32'h8000_1010);
        access(0, 32'h8000_2010, 2'b11, 0, 0, 0);
        chk("post_inv_cyc", r_cyc, 2 + BUS_LAT);
        chk("post_inv_nwb", r_nwb, 0);
        chk("post_inv_rd_addr", r_rd_addr, 32'h8000_2010);

        // Reset during WBUS: fill set 5, dirty way 0, force eviction
        for (int k = 0; k < 4; k++) access(0, 32'h8000_0050 + 32'(k) * 32'h800, 2'b11, 0, 0, 0);
        access(1, 32'h8000_0050, 2'b11, 64'h5555_AAAA_5555_AAAA, 0, 0);
        i_valid = 1'b1; i_reqtyp = 1'b0; i_addr = 32'h8000_2050; i_size = 2'b11;
        r_got = 1'b0;
        for (int c = 0; c < 20 && !r_got; c++) begin
            @(posedge i_clk); #1;
            if (o_mem_valid && o_mem_reqtyp) r_got = 1'b1;
        end
        chk("rst_wbus_seen", r_got, 1);
        chk("rst_wbus_addr", o_mem_addr, 32'h8000_0050);
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        chk("rst_abandon", o_mem_valid, 0);
        i_rst = 1'b0; i_valid = 1'b0;
        @(posedge i_clk); #1;
        access(0, 32'h8000_2050, 2'b11, 0, 0, 0);
        chk("post_rst_cyc", r_cyc, 2 + BUS_LAT);
        chk("post_rst_nwb", r_nwb, 0);
        chk("post_rst_nrd", r_nrd, 1);
        access(0, 32'h8000_0050, 2'b11, 0, 0, 0);
        chk("post_rst_miss_cyc", r_cyc, 2 + BUS_LAT);
        chk("post_rst_miss_nwb", r_nwb, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dcache_nway.md
Name: dcache_nway

Overview:
- Parametrised write-back, write-allocate, N-way set-associative data cache between the LSU (64-bit request port) and the memory bus (one cache line per transfer).
- Successor of the current 2-way/128-set dCache:
  - Way count, set count and line size are parameters.
  - Replacement is per-set round-robin with invalid-way preference.
  - Clean operation gains an optional invalidate mode.

Parameters:
- ADDR_W, 32, address width.
- WAYS, 4, associativity; power of two, 1..8.
- SETS, 128, sets per way; power of two, ≥2.
- LINE_BYTES, 16, line size in bytes; power of two, 8..64.
- Derived: OFF_W=log2(LINE_BYTES), IDX_W=log2(SETS), TAG_W=ADDR_W-IDX_W-OFF_W, LINE_W=LINE_BYTES*8.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset; synchronous, active-high
- i_valid  in  1  request valid; held with all request fields stable until o_ready
- i_reqtyp  in  1  0=REQ_READ, 1=REQ_WRITE
- i_addr  in  ADDR_W  byte address; naturally aligned to i_size
- i_size  in  2  00=1B, 01=2B, 10=4B, 11=8B
- i_wdata  in  64  store data, LSB-aligned
- i_clean  in  1  with i_valid: clean request (fence); address/type ignored
- i_inval  in  1  with i_clean: also invalidate every line
- o_ready  out  1  one-cycle completion pulse
- o_rdata  out  64  load data, valid while o_ready
- o_mem_valid  out  1  bus request
- o_mem_reqtyp  out  1  0=read line, 1=write line
- o_mem_addr  out  ADDR_W  line-aligned address (low OFF_W bits 0)
- o_mem_wdata  out  LINE_W  writeback line
- o_mem_size  out  2  constant 2'b11
- i_mem_ready  in  1  bus completion
- i_mem_rdata  in  LINE_W  fill line, valid with i_mem_ready

Behaviour:
- Clock and reset: one clock, i_clk. Reset is synchronous and active-high on i_rst.
- Reset values:
  - State IDLE; all valid/dirty bits 0; all round-robin pointers 0; flush counter 0.
  - o_ready, o_mem_valid, o_mem_reqtyp, o_rdata all 0.
  - A bus transaction in progress is abandoned; the cache does not drive o_mem_valid in the cycle after i_rst is sampled.
- Address split: tag=addr[ADDR_W-1:IDX_W+OFF_W], index=addr[IDX_W+OFF_W-1:OFF_W], offset=addr[OFF_W-1:0].
- Lookup: combinational tag compare of all ways of the indexed set in IDLE. hit[w] = valid[w] & tag match. At most one way hits.
- States: IDLE, HIT, WBUS, RBUS, CLN_SCAN, CLN_WBUS.
- IDLE, i_valid asserted:
  - i_clean → CLN_SCAN.
  - Any hit → HIT.
  - Victim valid & dirty → WBUS.
  - Otherwise → RBUS.
- HIT: o_ready=1 for exactly one cycle, then → IDLE.
  - Hit latency: request first seen in cycle N, o_ready in N+1.
  - Read: o_rdata = bits [63:0] of (line >> offset*8); bytes beyond the line end read 0.
  - Write: byte strobe (1/3/F/FF per size) << offset; store data << offset*8; dirty set; o_rdata=0.
- Victim selection:
  - Lowest-index invalid way in the set, if any.
  - Otherwise rr_ptr[index].
  - Selection is latched on leaving IDLE and stays fixed through WBUS/RBUS.
- WBUS:
  - o_mem_valid=1, reqtyp=1, addr={victim_tag,index,0}, wdata=victim line.
  - Fields held stable until i_mem_ready, then → RBUS.
  - On i_mem_ready the victim dirty bit is cleared.
- RBUS:
  - o_mem_valid=1, reqtyp=0, addr={tag,index,0}.
  - On i_mem_ready: write i_mem_rdata into the victim way, tag<=tag, valid=1, dirty=0.
  - If victim == rr_ptr, rr_ptr[index] <= rr_ptr+1 (wraps at WAYS).
  - → IDLE; the retained request then re-looks-up and hits.
  - Clean miss latency is 1 + bus cycles + 1 + 1.
- Pointer updates: rr_ptr changes on fills only, never on hits.
- CLN_SCAN:
  - Counter c runs over SETS*WAYS entries; way=c[high bits], set=c[low IDX_W bits].
  - Entry valid & dirty → CLN_WBUS with the same c.
  - Otherwise: if i_inval, clear valid; then either c==last → o_ready, reset c=0, → IDLE; or c+1 and stay in CLN_SCAN.
- CLN_WBUS:
  - Write the line to {tag,set,0}.
  - On i_mem_ready: dirty=0; valid=0 if i_inval.
  - Then either c==last → o_ready, c=0, → IDLE; or c+1 → CLN_SCAN.
- Clean completion: o_ready is asserted in the cycle the final entry completes. A clean with no dirty lines takes SETS*WAYS cycles.
- Bus handshake: o_mem_valid stays asserted until i_mem_ready; back-to-back transactions may be issued with no idle cycle. i_mem_ready while o_mem_valid=0 is ignored.
- No new request is sampled while not in IDLE. i_valid deasserting mid-miss is a protocol violation; behaviour in that case is undefined.

Test Plan:
- WAYS=4, LINE_BYTES=16, read 0x8000_0010 with cold cache:
  - RBUS read at addr 0x8000_0010; fill line 0x00112233_44556677_8899AABB_CCDDEEFF.
  - o_ready two cycles after i_mem_ready; o_rdata=0x8899AABB_CCDDEEFF.
- Write 8B 0xDEAD_BEEF_0000_0001 to 0x8000_0018 (hit):
  - o_ready in the next cycle.
  - Read back returns 0xDEAD_BEEF_0000_0001.
- Round-robin: fill 4 tags into set 1, then read a 5th tag:
  - Way 0 is evicted; since way 0 is dirty, a WBUS write to the old line address precedes RBUS.
  - A 6th tag evicts way 1.
- Clean with 2 dirty lines, i_inval=0:
  - Exactly 2 bus writes with correct line addresses.
  - o_ready after SETS*WAYS scan entries plus bus cycles.
  - A subsequent read of either address hits with no bus traffic.
- Clean with i_inval=1, then read a previously cached address:
  - Every line is invalidated.
  - The read misses and issues RBUS.
- Assert i_rst during WBUS with i_mem_ready held 0:
  - o_mem_valid=0 in the next cycle.
  - All lines invalid afterwards: the next read issues RBUS with no WBUS.
